// File: rtl/cga_comp_pkg.sv
// Shared constants for the CGA composite encoder: mode codes, colour-phase
// offsets, luma tables and DAC-width scaling.
package cga_comp_pkg;

    localparam int unsigned BASE_W = 7;

    localparam logic [1:0] MODE_OLD = 2'b00;
    localparam logic [1:0] MODE_NEW = 2'b01;

    // Colour-phase offsets in units of SC_CLKS/8 clk
    localparam int unsigned OFF_YELLOW  = 0;
    localparam int unsigned OFF_RED     = 2;
    localparam int unsigned OFF_MAGENTA = 3;
    localparam int unsigned OFF_BLUE    = 4;
    localparam int unsigned OFF_CYAN    = 6;
    localparam int unsigned OFF_GREEN   = 7;

    // Element [rgb] is the base luma for that RGB value
    localparam logic [7:0][6:0] LUMA_OLD =
        {7'd68, 7'd60, 7'd46, 7'd39, 7'd56, 7'd49, 7'd36, 7'd29};
    localparam logic [7:0][6:0] LUMA_NEW =
        {7'd68, 7'd63, 7'd45, 7'd41, 7'd57, 7'd52, 7'd33, 7'd29};

    localparam logic [6:0] INT_OLD = 7'd31;
    localparam logic [6:0] CHR_OLD = 7'd28;
    localparam logic [6:0] INT_NEW = 7'd28;
    localparam logic [6:0] CHR_NEW = 7'd26;

    function automatic logic [15:0] scale_lvl(input logic [6:0] value, input int unsigned out_w);
        return 16'(value) << (out_w - BASE_W);
    endfunction

endpackage

// File: rtl/cga_subcarrier_gen.sv
// Colour-subcarrier phase counter with run-time hue rotation; produces the
// pixel sample enable and the six colour-phase square waves.
module cga_subcarrier_gen
    import cga_comp_pkg::*;
#(
    parameter int unsigned SC_CLKS = 8
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] hue_adj,
    output logic       se_c,
    output logic [5:0] col_c
);

    localparam int unsigned PH_W = $clog2(SC_CLKS);
    localparam int unsigned K    = SC_CLKS / 8;

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;
    logic [PH_W-1:0] rot_c;

    function automatic logic phase_on(input logic [PH_W-1:0] rot, input int unsigned off);
        logic [PH_W-1:0] d;
        d = rot - PH_W'(off * K);
        return d < PH_W'(SC_CLKS / 2);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ph_q <= '0;
        else          ph_q <= ph_d;
    end

    always_comb begin
        ph_d  = (ph_q == PH_W'(SC_CLKS - 1)) ? '0 : ph_q + PH_W'(1);
        rot_c = ph_q - PH_W'(hue_adj) * PH_W'(K);
        se_c  = ph_q[0];
        // Bit order matches colour-select index 6..1
        col_c = {phase_on(rot_c, OFF_YELLOW), phase_on(rot_c, OFF_MAGENTA),
                 phase_on(rot_c, OFF_RED),    phase_on(rot_c, OFF_CYAN),
                 phase_on(rot_c, OFF_GREEN),  phase_on(rot_c, OFF_BLUE)};
    end

endmodule

// File: rtl/cga_composite_ng.sv
// CGA composite encoder: IRGB plus CRTC syncs in, composite sync, burst
// window and colour-modulated luma code out.
module cga_composite_ng
    import cga_comp_pkg::*;
#(
    parameter int unsigned OUT_W       = 7,
    parameter int unsigned SC_CLKS     = 8,
    parameter int unsigned HS_START    = 2,
    parameter int unsigned HS_END      = 6,
    parameter int unsigned BURST_START = 7,
    parameter int unsigned BURST_END   = 9,
    parameter int unsigned HCNT_MAX    = 11,
    parameter int unsigned VS_LINES    = 3
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lclk,
    input  logic             hclk,
    input  logic [3:0]       video,
    input  logic             hsync,
    input  logic             vsync_l,
    input  logic [1:0]       mode,
    input  logic [2:0]       hue_adj,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             csync_out,
    output logic             burst_out,
    output logic [OUT_W-1:0] comp_video
);

    localparam int unsigned HC_W  = $clog2(HCNT_MAX + 1);
    localparam int unsigned VC_W  = $clog2(VS_LINES + 2);
    localparam int unsigned SUM_W = OUT_W + 1;

    logic             se_c;
    logic [5:0]       col_c;

    logic             hclk_q, hclk_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [HC_W-1:0]  hcount_q, hcount_d;
    logic [VC_W-1:0]  vcount_q, vcount_d;
    logic [3:0]       vid_q, vid_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             sync_x_q, sync_x_d;
    logic             burst_q, burst_d;
    logic [OUT_W-1:0] comp_q, comp_d;

    logic             vtrig_c;
    logic             hsync_c, vsync_c, csync_c, burst_c;
    logic [2:0]       idx_c;
    logic [7:0]       sel_c;
    logic             chroma_c, new_c;
    logic [6:0]       luma_c, int_c, chr_c;
    logic [SUM_W-1:0] sum_c;
    logic [OUT_W-1:0] level_c;

    cga_subcarrier_gen #(.SC_CLKS(SC_CLKS)) u_sc (
        .clk     (clk),
        .reset_n (reset_n),
        .hue_adj (hue_adj),
        .se_c    (se_c),
        .col_c   (col_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hclk_q   <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            vid_q    <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            sync_x_q <= 1'b0;
            burst_q  <= 1'b0;
            comp_q   <= '0;
        end else begin
            hclk_q   <= hclk_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            vid_q    <= vid_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            sync_x_q <= sync_x_d;
            burst_q  <= burst_d;
            comp_q   <= comp_d;
        end
    end

    // Sync sampling, character counter and vsync line counter
    always_comb begin
        hclk_d   = hclk;
        hs_d     = hs_q;
        vs_d     = vs_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        vid_d    = vid_q;

        if (hclk && !hclk_q) begin
            hs_d = hsync;
            vs_d = vsync_l;
        end
        if (se_c) vid_d = video;

        if (lclk) begin
            if (!hs_q || hcount_q == HC_W'(HCNT_MAX)) hcount_d = '0;
            else                                      hcount_d = hcount_q + HC_W'(1);
        end

        vtrig_c = lclk && hs_q && (hcount_q == HC_W'(1));
        if (vtrig_c) begin
            if (!vs_q)                                  vcount_d = '0;
            else if (vcount_q != VC_W'(VS_LINES + 1))   vcount_d = vcount_q + VC_W'(1);
        end
    end

    // Sync windows, colour select and luma sum for the output stage
    always_comb begin
        hsync_c  = (hcount_q >= HC_W'(HS_START)) && (hcount_q < HC_W'(HS_END));
        vsync_c  = (vcount_q != '0) && (vcount_q <= VC_W'(VS_LINES));
        csync_c  = ~(hsync_c ^ vsync_c);
        burst_c  = !mode[1] && !vs_q &&
                   (hcount_q >= HC_W'(BURST_START)) && (hcount_q < HC_W'(BURST_END));

        idx_c    = {vid_q[2] ^ burst_c, vid_q[1] ^ burst_c, vid_q[0]};
        sel_c    = {1'b1, col_c, 1'b0};
        chroma_c = mode[1] ? (|vid_q[2:0]) : sel_c[idx_c];

        new_c    = (mode == MODE_NEW);
        luma_c   = new_c ? LUMA_NEW[vid_q[2:0]] : LUMA_OLD[vid_q[2:0]];
        int_c    = vid_q[3] ? (new_c ? INT_NEW : INT_OLD) : 7'd0;
        chr_c    = chroma_c ? (new_c ? CHR_NEW : CHR_OLD) : 7'd0;

        sum_c    = SUM_W'(scale_lvl(luma_c, OUT_W)) + SUM_W'(scale_lvl(int_c, OUT_W)) +
                   SUM_W'(scale_lvl(chr_c, OUT_W));
        level_c  = sum_c[OUT_W] ? {OUT_W{1'b1}} : sum_c[OUT_W-1:0];

        hsync_d  = hsync_c;
        vsync_d  = vsync_c;
        sync_x_d = hsync_c ^ vsync_c;
        burst_d  = burst_c;
        comp_d   = csync_c ? level_c : '0;
    end

    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign csync_out  = ~sync_x_q;
    assign burst_out  = burst_q;
    assign comp_video = comp_q;

endmodule

// File: tb/tb_cga_composite_ng.sv
// Randomised and directed bench for cga_composite_ng against a cycle-level
// behavioural model built from the encoder's timing and luma rules.
module tb_cga_composite_ng;

    localparam int SC = 8;
    localparam int K  = SC / 8;
    localparam int P  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lclk, hclk, hsync, vsync_l;
    logic [3:0] video;
    logic [1:0] mode;
    logic [2:0] hue_adj;
    logic       hsync_out, vsync_out, csync_out, burst_out;
    logic [6:0] comp_video;

    cga_composite_ng dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lclk       (lclk),
        .hclk       (hclk),
        .video      (video),
        .hsync      (hsync),
        .vsync_l    (vsync_l),
        .mode       (mode),
        .hue_adj    (hue_adj),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .csync_out  (csync_out),
        .burst_out  (burst_out),
        .comp_video (comp_video)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    int old_t[8] = '{29, 36, 49, 56, 39, 46, 60, 68};
    int new_t[8] = '{29, 33, 52, 57, 41, 45, 63, 68};
    // Phase offset per colour-select index (1 blue .. 6 yellow)
    int off_t[8] = '{0, 4, 7, 6, 2, 3, 0, 0};

    int m_ph, m_vid, m_hclk, m_hs, m_vs, m_hc, m_vc, m_last_ph;
    int e_hs, e_vs, e_cs, e_bu, e_cv;
    int lcnt = 0;
    int cnt_hs, cnt_bu, cnt_vs;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int col_on(input int off);
        int v;
        v = m_ph - off * K - int'(hue_adj) * K;
        v = ((v % SC) + SC) % SC;
        return (v < SC / 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_vid = 0; m_hclk = 0; m_hs = 0; m_vs = 0; m_hc = 0; m_vc = 0;
        m_last_ph = 0;
        e_hs = 0; e_vs = 0; e_cs = 1; e_bu = 0; e_cv = 0;
    endtask

    task automatic model_clk();
        int hs_o, vs_o, bu, r, g, b, idx, chroma, newt, lum;
        hs_o = (m_hc >= 2 && m_hc < 6) ? 1 : 0;
        vs_o = (m_vc >= 1 && m_vc <= 3) ? 1 : 0;
        bu   = (mode < 2 && m_vs == 0 && m_hc >= 7 && m_hc < 9) ? 1 : 0;
        r    = ((m_vid >> 2) & 1) ^ bu;
        g    = ((m_vid >> 1) & 1) ^ bu;
        b    = m_vid & 1;
        idx  = r * 4 + g * 2 + b;
        if (mode >= 2)      chroma = ((m_vid & 7) != 0) ? 1 : 0;
        else if (idx == 0)  chroma = 0;
        else if (idx == 7)  chroma = 1;
        else                chroma = col_on(off_t[idx]);
        newt = (mode == 1) ? 1 : 0;
        lum  = newt ? new_t[m_vid & 7] : old_t[m_vid & 7];
        if (m_vid >= 8) lum += newt ? 28 : 31;
        if (chroma != 0) lum += newt ? 26 : 28;
        if (lum > 127) lum = 127;
        e_hs = hs_o; e_vs = vs_o; e_cs = (hs_o == vs_o) ? 1 : 0; e_bu = bu;
        e_cv = e_cs ? lum : 0;
        m_last_ph = m_ph;
        if (lclk && m_hs != 0 && m_hc == 1) m_vc = (m_vs != 0) ? ((m_vc < 4) ? m_vc + 1 : 4) : 0;
        if (lclk) m_hc = (m_hs == 0 || m_hc == 11) ? 0 : m_hc + 1;
        if (hclk && m_hclk == 0) begin
            m_hs = hsync;
            m_vs = vsync_l;
        end
        m_hclk = hclk;
        if (m_ph % 2 == 1) m_vid = video;
        m_ph = (m_ph + 1) % SC;
    endtask

    task automatic drive_next(input bit rnd);
        lcnt++;
        lclk = (lcnt % P == 0);
        if (lclk) hclk = ~hclk;
        if (rnd) begin
            video = 4'($urandom);
            if ($urandom_range(15) == 0)  mode    = 2'($urandom);
            if ($urandom_range(15) == 0)  hue_adj = 3'($urandom);
            if ($urandom_range(63) == 0)  hsync   = ~hsync;
            if ($urandom_range(255) == 0) vsync_l = ~vsync_l;
        end
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_clk();
            @(negedge clk);
            chk("hsync_out", int'(hsync_out), e_hs);
            chk("vsync_out", int'(vsync_out), e_vs);
            chk("csync_out", int'(csync_out), e_cs);
            chk("burst_out", int'(burst_out), e_bu);
            chk("comp_video", int'(comp_video), e_cv);
            cnt_hs += int'(hsync_out);
            cnt_bu += int'(burst_out);
            cnt_vs += int'(vsync_out);
            drive_next(rnd);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"}, int'(hsync_out), 0);
        chk({tag, "_vsync"}, int'(vsync_out), 0);
        chk({tag, "_csync"}, int'(csync_out), 1);
        chk({tag, "_burst"}, int'(burst_out), 0);
        chk({tag, "_comp"},  int'(comp_video), 0);
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive_next(1'b0);
    endtask

    initial begin
        int p;
        reset_n = 1'b0; lclk = 1'b0; hclk = 1'b0; hsync = 1'b0; vsync_l = 1'b0;
        video = 4'h0; mode = 2'b00; hue_adj = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Full white, sync inactive
        video = 4'hF;
        run(6, 1'b0);
        repeat (8) begin
            run(1, 1'b0);
            chk("white_const", int'(comp_video), 127);
        end

        // Blue phase at several hue settings
        video = 4'h1;
        run(4, 1'b0);
        repeat (16) begin
            run(1, 1'b0);
            p = m_last_ph;
            chk("blue_h0", int'(comp_video), (p >= 4 && p <= 7) ? 64 : 36);
        end
        hue_adj = 3'd2;
        repeat (16) begin
            run(1, 1'b0);
            p = m_last_ph;
            chk("blue_h2", int'(comp_video), (p >= 6 || p <= 1) ? 64 : 36);
        end
        hue_adj = 3'd7;
        repeat (16) begin
            run(1, 1'b0);
            p = m_last_ph;
            chk("blue_h7", int'(comp_video), (p >= 3 && p <= 6) ? 64 : 36);
        end
        hue_adj = 3'd0;

        // Horizontal sync and burst windows over one full line
        video = 4'h0; hsync = 1'b1; vsync_l = 1'b0;
        run(16 * P, 1'b0);
        cnt_hs = 0; cnt_bu = 0; cnt_vs = 0;
        run(12 * P, 1'b0);
        chk("hsync_per_line", cnt_hs, 4 * P);
        chk("burst_per_line", cnt_bu, 2 * P);

        // Five-line vsync: three lines of vsync_out, burst suppressed
        cnt_vs = 0;
        vsync_l = 1'b1;
        run(3 * P, 1'b0);
        cnt_bu = 0;
        run(57 * P, 1'b0);
        chk("burst_in_vsync", cnt_bu, 0);
        vsync_l = 1'b0;
        run(40 * P, 1'b0);
        chk("vsync_len", cnt_vs, 36 * P);

        // Monochrome luma
        mode = 2'b10; video = 4'h9; hsync = 1'b0;
        run(8 * P, 1'b0);
        repeat (8) begin
            run(1, 1'b0);
            chk("mono_95", int'(comp_video), 95);
        end

        // Reset in the middle of a line
        mode = 2'b00; hsync = 1'b1;
        run(7 * P + 1, 1'b0);
        mid_reset();

        // Randomised traffic, with another reset partway
        run(1500, 1'b1);
        mid_reset();
        run(1500, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cga_composite_ng.md
Name: cga_composite_ng

Overview:
- Next-generation CGA composite encoder: IRGB pixels plus CGA hsync/vsync in, composite sync and colour-modulated luma code out, for the on-chip composite DAC path.
- Extends the fixed-function encoder with:
  - a parametrised DAC width;
  - a parametrised subcarrier period generated by a phase counter;
  - run-time hue rotation;
  - an old/new-CGA luma mode;
  - parametrised sync/burst windows;
  - a separate csync/burst tap for the scaler overlay.

Parameters:
- OUT_W, 7, comp_video width; legal 7..10; luma codes scaled by 2^(OUT_W-7).
- SC_CLKS, 8, clk cycles per colour-subcarrier period; legal 8 or 16.
- HS_START, 2, first hcount value with hsync_out=1.
- HS_END, 6, first hcount value with hsync_out=0 again.
- BURST_START, 7, first hcount value of the burst window.
- BURST_END, 9, first hcount value after the burst window.
- HCNT_MAX, 11, hcount wrap value.
- VS_LINES, 3, vsync_out length in hsync pulses.

Ports:
- clk  in  1  28.636 MHz master clock
- reset_n  in  1  asynchronous, active-low reset
- lclk  in  1  character-clock enable, one clk wide
- hclk  in  1  CRTC clock level; rising edge detected internally
- video  in  4  IRGB pixel
- hsync  in  1  CRTC hsync, active high
- vsync_l  in  1  CRTC vsync
- mode  in  2  00 colour/old-CGA luma; 01 colour/new-CGA luma; 10, 11 monochrome
- hue_adj  in  3  subcarrier phase rotation, in SC_CLKS/8 clk steps
- hsync_out  out  1  composite hsync
- vsync_out  out  1  composite vsync
- csync_out  out  1  ~(hsync_out ^ vsync_out)
- burst_out  out  1  burst window active
- comp_video  out  OUT_W  composite level code

Behaviour:
- Reset: all registers 0; all outputs 0 except csync_out=1 (hsync_out=vsync_out=0); hcount=0, vcount=0, ph=0.
- Phase counter ph (log2 SC_CLKS bits): increments every clk and wraps at SC_CLKS-1.
- Sample enable se = (ph[0]==1); this is the 14.318 MHz falling edge. vid_q <= video on se.
- Colour phases: k = SC_CLKS/8. Offsets in clk units: yellow 0, red 2k, magenta 3k, blue 4k, cyan 6k, green 7k.
- A colour is on when ((ph - off - hue_adj*k) mod SC_CLKS) < SC_CLKS/2. hue_adj=0 gives the legacy phase relationship.
- Sync sampling: on the hclk rising edge (hclk & ~hclk_q), hs_q <= hsync and vs_q <= vsync_l.
- hcount, on lclk:
  - if hs_q=0 → 0;
  - else if hcount==HCNT_MAX → 0;
  - else +1.
- vtrig: one-clk pulse when hcount goes 1→2.
- hsync_out = HS_START <= hcount < HS_END.
- Burst: burst = (mode<2) & ~vs_q & (BURST_START <= hcount < BURST_END).
- vcount updates on vtrig:
  - vs_q=0 → 0;
  - else saturating +1, max VS_LINES+1.
- vsync_out = 1 <= vcount <= VS_LINES.
- Colour select: index {R^burst, G^burst, B}:
  - 0 → off; 1 → blue; 2 → green; 3 → cyan; 4 → red; 5 → magenta; 6 → yellow; 7 → on.
  - Monochrome: chroma bit = (vid_q[2:0]!=0).
- Luma tables (base OUT_W=7) for RGB=0..7:
  - old: 29,36,49,56,39,46,60,68; intensity +31; chroma +28.
  - new: 29,33,52,57,41,45,63,68; intensity +28; chroma +26.
- Arithmetic: the sum is evaluated at OUT_W+1 bits and saturated at 2^OUT_W-1. The maximum legal-table sum (127) never saturates at OUT_W=7.
- comp_video is registered, one clk after the combinational result; it is 0 whenever csync is low. csync_out and burst_out are registered in the same stage, so they stay aligned with comp_video.
- mode and hue_adj changes take effect on the next clk; no glitch filtering.
- lclk and vtrig in the same cycle: the vcount update uses the pre-increment hcount.
- Mid-operation reset: outputs go to reset values immediately (asynchronously).

Decomposition:
- Package cga_comp_pkg holds:
  - mode encoding constants;
  - the colour-phase offset constants;
  - the old and new luma tables and the intensity/chroma increments;
  - the function scale_lvl(value, OUT_W).
- Sub-module cga_subcarrier_gen (clk, reset_n, hue_adj → ph, se, six colour-phase bits): isolates the phase counter, SC_CLKS generalisation and hue rotation.

Test Plan:
- Defaults, mode=00, hue_adj=0, video=4'hF steady, hsync low → comp_video=127 constant.
- video=4'h1 (blue), mode=00 → comp_video alternates 64/36, 4 clk on and 4 off, with the on-window starting at ph=4.
- Same as previous with hue_adj=2 → waveform shifted by 2 clk; hue_adj=0 vs 7 differ by a 1-clk lag.
- hsync held high for 12 lclk pulses with vsync_l=0 → hsync_out high for hcount 2..5 and burst_out high at hcount 7..8. During sync, comp_video=0; during burst it carries the yellow phase.
- vsync_l high across 5 lines → vsync_out high for exactly 3 vtrig intervals; burst_out stays 0 throughout.
- mode=10, video=4'h9 → comp_video constant 36+31+28=95; reset_n pulsed low mid-line → all outputs reset in the same cycle and csync_out=1.
